sfx_arbiter: RTL
================

SFX_ARBITER -- requirements
Module: sfx_arbiter

Interface
REQ-001 Parameter TICK_CYCLES, default 1_000_000, clk cycles per duration tick (10 ms at 100 MHz); legal >= 1.
REQ-002 Parameter GAP_TICKS, default 1, silent ticks inserted after each completed note; 0 = no gap.
REQ-003 Parameter PREEMPT, default 1; 1 = higher-priority request aborts a playing note, 0 = waits.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  4  per-requester play request, level; requester 0 highest priority.
REQ-007 note_div_req  in  88  requester i divider at bits [22*i+21:22*i], format of the buzzer note_div input.
REQ-008 dur_req  in  32  requester i duration in ticks at bits [8*i+7:8*i].
REQ-009 ack  out  4  one-cycle pulse, request i accepted.
REQ-010 done  out  4  one-cycle pulse, requester i note completed.
REQ-011 drop  out  4  one-cycle pulse, requester i note aborted by preemption.
REQ-012 owner  out  2  index of requester currently playing.
REQ-013 busy  out  1  1 in PLAY and GAP.
REQ-014 note_div  out  22  divider to buzzer; 0 whenever mute=1.
REQ-015 mute  out  1  1 = buzzer output silenced.

Function
REQ-016 States IDLE, PLAY, GAP; all outputs registered.
REQ-017 IDLE: req sampled at edge N nonzero -> at edge N+1: state PLAY, owner = lowest set index, ack[owner]=1, note_div = latched note_div_req slice, mute=0, busy=1.
REQ-018 note_div and duration latched at grant; later changes on inputs ignored for that note.
REQ-019 dur 0 treated as 1.
REQ-020 Tick counter 0..TICK_CYCLES-1, cleared at each grant; remaining-tick counter decremented at wrap.
REQ-021 PLAY lasts exactly max(dur,1)*TICK_CYCLES cycles with note_div constant.
REQ-022 Completion: next cycle done[owner]=1, note_div=0, mute=1; state GAP if GAP_TICKS>0, else IDLE.
REQ-023 GAP: mute for GAP_TICKS*TICK_CYCLES cycles, busy=1, requests held pending, then IDLE; IDLE arbitration resumes on the following edge.
REQ-024 Requester holds req until ack; req[owner] is ignored during PLAY/GAP; a req still high after done is a new request.
REQ-025 PREEMPT=1, PLAY, req[j] with j<owner: next edge drop[owner]=1, ack[j]=1, owner=j, new note_div latched, counters restarted, stay PLAY; no done for aborted owner.
REQ-026 PREEMPT=1, preemption takes priority over completion if both occur in the same cycle.
REQ-027 PREEMPT=0: requests during PLAY wait for IDLE.
REQ-028 ack, done, drop are each at most one-hot and never high two consecutive cycles for the same grant.

Reset
REQ-029 rst=1 at an edge: state IDLE, ack=done=drop=0, owner=0, busy=0, note_div=0, mute=1, counters 0.
REQ-030 Reset mid-PLAY/GAP aborts silently: no done or drop pulse; pending requests re-arbitrated from the first edge after rst falls.

Verification (TICK_CYCLES=4, GAP_TICKS=1 unless stated)
REQ-031 req[2], note 191113, dur 3 -> ack[2] next cycle; note_div=191113, mute=0 for 12 cycles; done[2] pulse; mute=1 for 4 cycles; busy falls.
REQ-032 req[1] and req[3] same cycle -> ack[1] only; ack[3] one cycle after GAP ends.
REQ-033 req[3] playing (dur 5), req[0] at tick 1 -> drop[3], ack[0] same cycle, note_div switches to requester 0 value next edge, no done[3].
REQ-034 dur 0 -> note plays exactly 4 cycles; GAP_TICKS=0 -> done pulse with immediate IDLE, back-to-back req re-granted 1 cycle later.
REQ-035 rst asserted at cycle 6 of PLAY -> next cycle all outputs reset values, no done/drop.
REQ-036 PREEMPT=0, req[0] during requester 2 PLAY -> no drop; ack[0] after requester 2 done and GAP.

Source files
------------

// File: rtl/sfx_arbiter.sv
// Sound-effect arbiter: grants one of four requesters the buzzer for a
// fixed number of duration ticks, optionally followed by a silent gap.
// Requester 0 has the highest priority and may abort a lower-priority note.
module sfx_arbiter #(
  parameter int TICK_CYCLES = 1_000_000,
  parameter int GAP_TICKS   = 1,
  parameter int PREEMPT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [87:0] note_div_req,
  input  logic [31:0] dur_req,
  output logic [3:0]  ack,
  output logic [3:0]  done,
  output logic [3:0]  drop,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [21:0] note_div,
  output logic        mute
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [7:0]    GAP_LOAD  = 8'(GAP_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [7:0]      rem_q, rem_d;
  logic [1:0]      owner_q, owner_d;
  logic [3:0]      ack_q, ack_d;
  logic [3:0]      done_q, done_d;
  logic [3:0]      drop_q, drop_d;
  logic            busy_q, busy_d;
  logic            mute_q, mute_d;
  logic [21:0]     note_div_q, note_div_d;

  logic [1:0]      win_idx;
  logic            win_any;
  logic            tick_wrap;
  logic            last_tick;
  logic            preempt;
  logic            grant;
  logic [7:0]      grant_dur;

  // Decode the winning requester and the events that drive this cycle's transition
  always_comb begin
    win_idx = 2'd0;
    win_any = |req;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win_idx = 2'(i);
    end
    tick_wrap = (tick_q == TICK_LAST);
    last_tick = tick_wrap && (rem_q == 8'd1);
    // the owner's own req is never lower than owner_q, so it cannot self-preempt
    preempt   = (PREEMPT != 0) && (state_q == S_PLAY) && win_any && (win_idx < owner_q);
    grant     = ((state_q == S_IDLE) && win_any) || preempt;
    grant_dur = dur_req[8*win_idx +: 8];
    if (grant_dur == 8'd0) grant_dur = 8'd1;
  end

  // Next state and tick / remaining-tick counters
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    rem_d   = rem_q;
    if (grant) begin
      state_d = S_PLAY;
      tick_d  = '0;
      rem_d   = grant_dur;
    end else if (state_q != S_IDLE) begin
      tick_d = tick_wrap ? '0 : tick_q + TW'(1);
      if (tick_wrap) rem_d = rem_q - 8'd1;
      if (last_tick) begin
        tick_d = '0;
        if ((state_q == S_PLAY) && (GAP_TICKS > 0)) begin
          state_d = S_GAP;
          rem_d   = GAP_LOAD;
        end else begin
          state_d = S_IDLE;
          rem_d   = 8'd0;
        end
      end
    end
  end

  // Registered outputs derived from the same-cycle transition decision
  always_comb begin
    ack_d      = 4'd0;
    done_d     = 4'd0;
    drop_d     = 4'd0;
    owner_d    = owner_q;
    note_div_d = note_div_q;
    if (grant) begin
      ack_d[win_idx] = 1'b1;
      owner_d        = win_idx;
      note_div_d     = note_div_req[22*win_idx +: 22];
    end
    if (preempt) drop_d[owner_q] = 1'b1;
    // preemption wins over completion, so an aborted owner never sees done
    if ((state_q == S_PLAY) && !grant && last_tick) done_d[owner_q] = 1'b1;
    if (state_d != S_PLAY) note_div_d = 22'd0;
    busy_d = (state_d != S_IDLE);
    mute_d = (state_d != S_PLAY);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      rem_q      <= 8'd0;
      owner_q    <= 2'd0;
      ack_q      <= 4'd0;
      done_q     <= 4'd0;
      drop_q     <= 4'd0;
      busy_q     <= 1'b0;
      mute_q     <= 1'b1;
      note_div_q <= 22'd0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      rem_q      <= rem_d;
      owner_q    <= owner_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      busy_q     <= busy_d;
      mute_q     <= mute_d;
      note_div_q <= note_div_d;
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign drop     = drop_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign mute     = mute_q;
  assign note_div = note_div_q;

endmodule
